// File: rtl/button_debouncer.sv
// Debounces a raw push-button level: dout follows btn_in only after the new value holds for N+1 samples.
// Define DEBOUNCE_SYNC_EN to add a two-flop input synchronizer (latency N+2 instead of N).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic dout,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LO,
        CHK_HI,
        IDLE_HI,
        CHK_LO
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s;

`ifdef DEBOUNCE_SYNC_EN
    logic sync1;
    logic sync2;

    // NOTE: non-blocking assignments make sync2 take the old sync1, giving two real flop stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = btn_in;
`endif

    // A reversal is tested before the terminal count, so a bounce on the last cycle still rejects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_LO;
            cnt   <= '0;
            dout  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE_LO: begin
                    if (s) begin
                        state <= CHK_HI;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state <= IDLE_LO;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_HI;
                        dout  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE_HI: begin
                    if (!s) begin
                        state <= CHK_LO;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state <= IDLE_HI;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE_LO;
                        dout  <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                    dout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw, bouncing push-button or switch level into a clean, glitch-free level.
- Sits directly upstream of the single pulser: `dout` drives the pulser's `din`, so one physical press yields exactly one `d_pulse`.
- Optionally synchronizes the asynchronous input, then requires the input to hold a new value for a programmable number of consecutive cycles before `dout` follows it.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: stability window N in clock cycles (5 ms at 50 MHz). Legal range: N ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: counter width. It must hold N-1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_in`  in  1  raw, asynchronous, bouncing input level.
- `dout`  out  1  debounced level, registered; feeds the single pulser's `din`.
- `busy`  out  1  high while a candidate transition is being qualified, registered.

## Operation
- Synchronizer: `btn_in` → `sync1` → `sync2`. Call the FSM's sampled input `s` (`s` = `sync2`, or `btn_in` when the synchronizer is compiled out).
- Counter: `cnt`, CNT_W bits, counts up only and never wraps. It is cleared on every state entry into a CHK state.
- FSM has four states, evaluated each rising edge:
  - IDLE_LO (`dout`=0, `busy`=0): if s=1, go to CHK_HI and set cnt←0. Otherwise stay.
  - CHK_HI (`dout`=0, `busy`=1): if s=0, go to IDLE_LO (glitch rejected). Else if cnt==N-1, go to IDLE_HI. Else cnt←cnt+1.
  - IDLE_HI (`dout`=1, `busy`=0): if s=0, go to CHK_LO and set cnt←0. Otherwise stay.
  - CHK_LO (`dout`=1, `busy`=1): if s=1, go to IDLE_HI. Else if cnt==N-1, go to IDLE_LO. Else cnt←cnt+1.
- Priority in CHK states: the s-reverted test is evaluated before the cnt==N-1 test. A reversal on the final qualifying cycle rejects the transition.
- Outputs are registered and decoded from the state register, not from `s`. `dout` therefore never glitches.
- Qualification rule: `s` must be sampled at the new value on N+1 consecutive edges. Any single opposite sample restarts qualification from the idle state.
- Reset (`rst_n`=0, asynchronous, at any time including mid-CHK): state←IDLE_LO, cnt←0, sync1←0, sync2←0, `dout`←0, `busy`←0. Operation resumes on the first rising edge after `rst_n` deasserts.
- If the input is held high through reset release: a normal rising qualification follows, and `dout` rises after the full latency.

## Timing
- Let edge a be the first rising edge at which `btn_in` is stably at its new value.
- With the synchronizer: `s` changes after edge a+1, CHK is entered at edge a+2, and `dout` changes at edge a+2+N. Latency is N+2 cycles.
- Without the synchronizer: CHK is entered at edge a, and `dout` changes at edge a+N. Latency is N cycles.
- `busy` rises at CHK entry and falls on the same edge that `dout` toggles or the check aborts.
- Minimum accepted pulse: N+1 cycles of stable `btn_in`. Any pulse of N cycles or fewer is rejected.
- Rising and falling qualification are symmetric: identical latency and rejection rules.

## Configuration
- `DEBOUNCE_SYNC_EN`
  - Defined: the two-flop synchronizer is present, and latency is N+2.
  - Undefined: `s` = `btn_in`, with no synchronizer flops and latency N. This mode is only for inputs already synchronous to `clk`.

## Test plan
- Reset: `rst_n`=0 with `btn_in`=1 → `dout`=0 and `busy`=0 immediately (asynchronous). After release with N=4 and sync enabled, `dout`=1 six edges after the first edge with `rst_n`=1.
- Clean press (N=4, sync enabled): `btn_in` 0→1 stable before edge a → `busy`=1 after edge a+2 and `dout`=1 after edge a+6. `busy`=0 at the same edge.
- Glitch rejection (N=4): `btn_in` high for exactly 4 cycles → `busy` pulses for 4 cycles and `dout` stays 0. Repeating with 5 cycles high → `dout` rises.
- Bounce (N=4): `btn_in` toggles 1,0,1,1,0,1 at one-cycle intervals, then holds 1 → `dout` rises exactly once, 6 edges after the final 0→1.
- Release and mid-check reset (N=4): with `dout`=1, drop `btn_in` to 0 → `dout`=0 after 6 edges. During a later CHK_HI, pulse `rst_n` low → `dout`=0, `busy`=0, and the counter is cleared.
- Chained with single_pulser (N=4): one bouncy press → exactly one `d_pulse` of one cycle.
